pushbutton_debounce: RTL and testbench



---
 rtl/pushbutton_debounce.sv | 104 ++++++++++
 tb/tb_pushbutton_debounce.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_debounce.sv
// pushbutton_debounce
//   Per-button input conditioner in front of the pushbutton AXI4-Lite register
//   file. Each raw pin is synchronised to ACLK with two flops. A stability
//   counter then debounces it into a clean level with single-cycle press and
//   release pulses. Press events are latched in write-1-to-clear sticky bits,
//   which drive a registered level interrupt.
//
// Ports
//   ACLK           system clock; all state changes on the rising edge
//   ARESET         synchronous, active-high reset
//   btn_in         raw asynchronous button pins, active high
//   clr_valid      one-cycle strobe from the AXI slave write-1-to-clear
//   clr_mask       press_sticky bits to clear when clr_valid is high
//   irq_en         per-button interrupt enable
//   btn_level      debounced level
//   press_pulse    one-cycle pulse on a debounced 0->1 transition
//   release_pulse  one-cycle pulse on a debounced 1->0 transition
//   press_sticky   latched press events
//   irq            registered OR of (press_sticky & irq_en)

module pushbutton_debounce #(
    parameter int unsigned NUM_BTN         = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    localparam int unsigned CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               clr_valid,
    input  logic [NUM_BTN-1:0] clr_mask,
    input  logic [NUM_BTN-1:0] irq_en,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] release_pulse,
    output logic [NUM_BTN-1:0] press_sticky,
    output logic               irq
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q, sync2_q;
    logic [CNT_W-1:0]   cnt_q [NUM_BTN];
    logic [CNT_W-1:0]   cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0] level_q, level_d;
    logic [NUM_BTN-1:0] press_q, press_d;
    logic [NUM_BTN-1:0] release_q, release_d;
    logic [NUM_BTN-1:0] sticky_q, sticky_d;
    logic               irq_q, irq_d;

    always_comb begin
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    // Input has differed for DEBOUNCE_CYCLES consecutive cycles.
                    level_d[i]   = sync2_q[i];
                    press_d[i]   = sync2_q[i];
                    release_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Set beats clear so a press landing with a clear is never lost.
        sticky_d = (sticky_q & ~(clr_mask & {NUM_BTN{clr_valid}})) | press_q;
        irq_d    = |(sticky_q & irq_en);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            sticky_q  <= '0;
            irq_q     <= 1'b0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= btn_in;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            sticky_q  <= sticky_d;
            irq_q     <= irq_d;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign press_sticky  = sticky_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_pushbutton_debounce.sv
// Directed bench for pushbutton_debounce with NUM_BTN=5, DEBOUNCE_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_pushbutton_debounce;

    logic       tb_ACLK;
    logic       ARESET;
    logic [4:0] btn_in;
    logic       clr_valid;
    logic [4:0] clr_mask;
    logic [4:0] irq_en;
    logic [4:0] btn_level;
    logic [4:0] press_pulse;
    logic [4:0] release_pulse;
    logic [4:0] press_sticky;
    logic       irq;

    int n_assert = 0;
    int n_fail   = 0;

    pushbutton_debounce #(
        .NUM_BTN        (5),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .ACLK         (tb_ACLK),
        .ARESET       (ARESET),
        .btn_in       (btn_in),
        .clr_valid    (clr_valid),
        .clr_mask     (clr_mask),
        .irq_en       (irq_en),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .press_sticky (press_sticky),
        .irq          (irq)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic tick();
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // btn_in was just changed: edge E samples it, no pulse through E+8,
    // level and pulse update at E+9.
    task automatic run_debounce(input string tag, input logic [4:0] lvl_exp,
                                input logic [4:0] press_exp, input logic [4:0] rel_exp);
        tick();
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk({tag, "_early_press"}, press_pulse, 5'h00);
            chk({tag, "_early_release"}, release_pulse, 5'h00);
        end
        tick();
        chk({tag, "_level"}, btn_level, lvl_exp);
        chk({tag, "_press"}, press_pulse, press_exp);
        chk({tag, "_release"}, release_pulse, rel_exp);
    endtask

    initial begin
        ARESET    = 1'b1;
        btn_in    = 5'h1F;
        clr_valid = 1'b0;
        clr_mask  = 5'h00;
        irq_en    = 5'h00;

        // 1. Reset with all pins high, then re-debounce from zero.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rst_outs", {btn_level, press_pulse, release_pulse, press_sticky},
                32'h0);
            chk("t1_rst_irq", irq, 1'b0);
        end
        ARESET = 1'b0;
        run_debounce("t1", 5'h1F, 5'h1F, 5'h00);
        tick();
        chk("t1_pulse_width", press_pulse, 5'h00);
        chk("t1_sticky", press_sticky, 5'h1F);
        chk("t1_irq_disabled", irq, 1'b0);
        clr_valid = 1'b1;
        clr_mask  = 5'h1F;
        tick();
        clr_valid = 1'b0;
        clr_mask  = 5'h00;
        chk("t1_clear_all", press_sticky, 5'h00);
        btn_in = 5'h00;
        repeat (10) tick();
        chk("t1_released", btn_level, 5'h00);
        chk("t1_sticky_after_release", press_sticky, 5'h00);

        // 2. Clean press on button 0 with its interrupt enabled.
        irq_en = 5'h01;
        btn_in = 5'h01;
        run_debounce("t2", 5'h01, 5'h01, 5'h00);
        tick();
        chk("t2_pulse_width", press_pulse, 5'h00);
        chk("t2_sticky", press_sticky, 5'h01);
        chk("t2_irq_lag", irq, 1'b0);
        tick();
        chk("t2_irq", irq, 1'b1);

        // 3. Button 2: high 7 cycles, low 1, then high -> first attempt rejected.
        btn_in = 5'h05;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("t3_bounce_press", press_pulse, 5'h00);
        end
        btn_in = 5'h01;
        tick();
        chk("t3_bounce_press_low", press_pulse, 5'h00);
        btn_in = 5'h05;
        run_debounce("t3", 5'h05, 5'h04, 5'h00);
        tick();
        chk("t3_sticky", press_sticky, 5'h05);

        // 4. Release button 0; sticky bit must survive.
        btn_in = 5'h04;
        run_debounce("t4", 5'h04, 5'h00, 5'h01);
        chk("t4_sticky_kept", press_sticky, 5'h05);
        tick();
        chk("t4_release_width", release_pulse, 5'h00);
        chk("t4_sticky_kept2", press_sticky, 5'h05);

        // 5. Clear of button 1 in the same cycle as its press pulse.
        irq_en = 5'h02;
        tick();
        tick();
        chk("t5_irq_masked", irq, 1'b0);
        btn_in = 5'h06;
        run_debounce("t5", 5'h06, 5'h02, 5'h00);
        clr_valid = 1'b1;
        clr_mask  = 5'h02;
        tick();
        chk("t5_race_set_wins", press_sticky, 5'h07);
        chk("t5_irq_pre", irq, 1'b0);
        tick();
        chk("t5_cleared", press_sticky, 5'h05);
        chk("t5_irq_high", irq, 1'b1);
        clr_valid = 1'b0;
        clr_mask  = 5'h1F;
        tick();
        chk("t5_irq_drop", irq, 1'b0);
        chk("t5_mask_ignored", press_sticky, 5'h05);
        clr_mask = 5'h00;

        // 6. Buttons 3 and 4 rise 3 cycles apart -> pulses 3 cycles apart.
        btn_in = 5'h0E;
        for (int i = 0; i <= 13; i++) begin
            logic [4:0] exp_p;
            if (i == 3) btn_in = 5'h1E;
            tick();
            exp_p = (i == 9) ? 5'h08 : (i == 12) ? 5'h10 : 5'h00;
            chk($sformatf("t6_press_%0d", i), press_pulse, exp_p);
        end
        chk("t6_level", btn_level, 5'h1E);
        btn_in = 5'h0E;
        repeat (10) tick();
        chk("t6_btn4_released", btn_level, 5'h0E);

        // Reset in the middle of button 4's count: no pulse, count restarts.
        btn_in = 5'h1E;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_midcount_press", press_pulse, 5'h00);
        end
        ARESET = 1'b1;
        tick();
        tick();
        chk("t6_rst_outs", {btn_level, press_pulse, release_pulse, press_sticky}, 32'h0);
        chk("t6_rst_irq", irq, 1'b0);
        ARESET = 1'b0;
        run_debounce("t6r", 5'h1E, 5'h1E, 5'h00);
        tick();
        chk("t6r_sticky", press_sticky, 5'h1E);
        chk("t6r_pulse_width", press_pulse, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
